// File: rtl/rtc_uart_frame_decoder.sv
// UART command-frame decoder for the RTC set path.
// Hunts for SOF0 SOF1 CMD YY MO DD WW HH MI SS CHK EOF_B, checks the XOR
// checksum and end byte, then issues time and/or date write requests that
// are held until the RTC controller acknowledges with set_done.
module rtc_uart_frame_decoder #(
    parameter logic [7:0] SOF0        = 8'hF0,
    parameter logic [7:0] SOF1        = 8'hF1,
    parameter logic [7:0] EOF_B       = 8'hF2,
    parameter int         TIMEOUT_CYC = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_data_valid,
    input  logic        set_done,
    output logic        set_time,
    output logic [23:0] time_2_set,
    output logic        set_date,
    output logic [31:0] date_2_set,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    localparam int             CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_CMD     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_EOF     = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_SOF0,
        S_CMD,
        S_PAYLOAD,
        S_CHK,
        S_EOF,
        S_REQ_TIME,
        S_REQ_DATE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [7:0]      acc_reg, acc_next;
    logic [2:0]      idx_reg, idx_next;
    logic [1:0]      cmd_reg, cmd_next;
    logic [55:0]     payload_reg, payload_shift;
    logic [23:0]     time_reg;
    logic [31:0]     date_reg;
    logic            frame_ok_reg, frame_ok_next;
    logic            frame_err_reg, frame_err_next;
    logic [1:0]      err_code_reg, err_code_next;
    logic            shift_en;
    logic            accept;
    logic            in_frame;

    // Payload shifts one byte per PAYLOAD byte; after seven bytes it holds
    // {YY, MO, DD, WW, HH, MI, SS} with SS in the low byte.
    assign payload_shift[7:0] = uart_rx_data;
    generate
        for (genvar gi = 1; gi < 7; gi++) begin : g_shift
            assign payload_shift[8*gi +: 8] = payload_reg[8*(gi-1) +: 8];
        end
    endgenerate

    assign in_frame = (state_reg == S_GOT_SOF0) || (state_reg == S_CMD) ||
                      (state_reg == S_PAYLOAD)  || (state_reg == S_CHK) ||
                      (state_reg == S_EOF);

    // State and datapath registers; reset aborts any frame or request silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            idx_reg       <= '0;
            cmd_reg       <= '0;
            payload_reg   <= '0;
            time_reg      <= '0;
            date_reg      <= '0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            idx_reg       <= idx_next;
            cmd_reg       <= cmd_next;
            frame_ok_reg  <= frame_ok_next;
            frame_err_reg <= frame_err_next;
            err_code_reg  <= err_code_next;
            if (shift_en) begin
                payload_reg <= payload_shift;
            end
            if (accept && cmd_reg[0]) begin
                time_reg <= payload_reg[23:0];
            end
            if (accept && cmd_reg[1]) begin
                date_reg <= payload_reg[55:24];
            end
        end
    end

    // Parser / request sequencer next-state logic, inter-byte timeout included.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = '0;
        acc_next       = acc_reg;
        idx_next       = idx_reg;
        cmd_next       = cmd_reg;
        frame_ok_next  = 1'b0;
        frame_err_next = 1'b0;
        err_code_next  = err_code_reg;
        shift_en       = 1'b0;
        accept         = 1'b0;

        // Timeout only fires on cycles without a byte, so it never races the parser.
        if (in_frame && !uart_data_valid) begin
            if (cnt_reg == CNT_LAST) begin
                state_next     = S_IDLE;
                frame_err_next = 1'b1;
                err_code_next  = ERR_TIMEOUT;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end

        case (state_reg)
            S_IDLE: begin
                if (uart_data_valid && uart_rx_data == SOF0) begin
                    state_next = S_GOT_SOF0;
                end
            end
            S_GOT_SOF0: begin
                if (uart_data_valid) begin
                    if (uart_rx_data == SOF1) begin
                        state_next = S_CMD;
                    end else if (uart_rx_data != SOF0) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_CMD: begin
                if (uart_data_valid) begin
                    if (uart_rx_data == 8'h01 || uart_rx_data == 8'h02 ||
                        uart_rx_data == 8'h03) begin
                        state_next = S_PAYLOAD;
                        acc_next   = uart_rx_data;
                        idx_next   = '0;
                        cmd_next   = uart_rx_data[1:0];
                    end else begin
                        state_next     = S_IDLE;
                        frame_err_next = 1'b1;
                        err_code_next  = ERR_CMD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (uart_data_valid) begin
                    shift_en = 1'b1;
                    acc_next = acc_reg ^ uart_rx_data;
                    idx_next = idx_reg + 3'd1;
                    if (idx_reg == 3'd6) begin
                        state_next = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (uart_data_valid) begin
                    if (uart_rx_data != acc_reg) begin
                        state_next     = S_IDLE;
                        frame_err_next = 1'b1;
                        err_code_next  = ERR_CHK;
                    end else begin
                        state_next = S_EOF;
                    end
                end
            end
            S_EOF: begin
                if (uart_data_valid) begin
                    if (uart_rx_data != EOF_B) begin
                        state_next     = S_IDLE;
                        frame_err_next = 1'b1;
                        err_code_next  = ERR_EOF;
                    end else begin
                        accept        = 1'b1;
                        frame_ok_next = 1'b1;
                        state_next    = cmd_reg[0] ? S_REQ_TIME : S_REQ_DATE;
                    end
                end
            end
            S_REQ_TIME: begin
                if (set_done) begin
                    state_next = (cmd_reg == 2'd3) ? S_REQ_DATE : S_IDLE;
                end
            end
            S_REQ_DATE: begin
                if (set_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign set_time   = (state_reg == S_REQ_TIME);
    assign set_date   = (state_reg == S_REQ_DATE);
    assign busy       = set_time | set_date;
    assign time_2_set = time_reg;
    assign date_2_set = date_reg;
    assign frame_ok   = frame_ok_reg;
    assign frame_err  = frame_err_reg;
    assign err_code   = err_code_reg;

endmodule

// File: doc/rtc_uart_frame_decoder.md
# rtc_uart_frame_decoder

Parametrised UART command-frame decoder for the RTC set path. It sits between the UART receiver and the SD30xx RTC controller. It hunts for a framed, XOR-checksummed set command in the received byte stream and rejects malformed frames with an error code. Valid frames are converted into sequenced time and/or date write requests, each held until the controller acknowledges with `set_done`.

## Interface
Parameters:
- `SOF0`, 8'hF0: first start-of-frame byte.
- `SOF1`, 8'hF1: second start-of-frame byte.
- `EOF_B`, 8'hF2: end-of-frame byte.
- `TIMEOUT_CYC`, 50_000_000: maximum clk cycles allowed between bytes inside a frame. Must be ≥2. Counter width is `$clog2(TIMEOUT_CYC)`.

Ports:
- `clk` input 1: single clock. All logic on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `uart_rx_data` input 8: received byte, valid when `uart_data_valid` is high.
- `uart_data_valid` input 1: one-cycle strobe per received byte.
- `set_done` input 1: acknowledge from the RTC controller for the current request.
- `set_time` output 1: time write request, level, held until acknowledged.
- `time_2_set` output 24: {HH, MI, SS}, BCD.
- `set_date` output 1: date write request, level, held until acknowledged.
- `date_2_set` output 32: {YY, MO, DD, WW}, BCD.
- `busy` output 1: high while a request is outstanding.
- `frame_ok` output 1: one-cycle pulse when a frame is accepted.
- `frame_err` output 1: one-cycle pulse when a frame is rejected.
- `err_code` output 2: cause of the last rejection. 0 = timeout, 1 = bad CMD, 2 = checksum, 3 = bad EOF.

## Operation
- Frame format is 12 bytes: SOF0 SOF1 CMD YY MO DD WW HH MI SS CHK EOF_B.
- CHK is the XOR of CMD and the 7 payload bytes.
- CMD values:
  - 8'h01: set time only.
  - 8'h02: set date only.
  - 8'h03: set time, then date.
  - Any other value: error 1.
- The full payload is always transmitted. Fields not selected by CMD are ignored, and the corresponding output registers keep their previous value.
- States: IDLE, GOT_SOF0, CMD, PAYLOAD (byte index 0..6), CHK, EOF, REQ_TIME, REQ_DATE.
- Parser transitions happen only on cycles with `uart_data_valid` high:
  - IDLE: byte == SOF0 → GOT_SOF0. Any other byte stays in IDLE.
  - GOT_SOF0: SOF1 → CMD. SOF0 → stay in GOT_SOF0. Any other byte → IDLE, with no error.
  - CMD: valid command → PAYLOAD and the checksum accumulator is loaded with CMD. Invalid command → IDLE with error 1.
  - PAYLOAD: shift the byte into the payload register and XOR it into the accumulator. After index 6 → CHK.
  - CHK: byte ≠ accumulator → IDLE with error 2. Otherwise → EOF.
  - EOF: byte ≠ EOF_B → IDLE with error 3. Otherwise the frame is accepted:
    - Latch the selected fields.
    - Pulse `frame_ok`.
    - CMD 01 or 03 → REQ_TIME. CMD 02 → REQ_DATE.
- Timeout:
  - In GOT_SOF0 through EOF, a counter clears on every valid byte and increments otherwise.
  - When the counter reaches TIMEOUT_CYC−1 with no byte in that cycle → IDLE with error 0.
  - The counter is held at 0 in IDLE, REQ_TIME and REQ_DATE.
- REQ_TIME: `set_time` = 1. When `set_done` arrives:
  - CMD 03 → REQ_DATE.
  - Otherwise → IDLE.
- REQ_DATE: `set_date` = 1. When `set_done` arrives → IDLE.
- `busy` = 1 in REQ_TIME and REQ_DATE.
- Bytes arriving while `busy` is high are dropped, with no error and no parsing.
- `set_done` seen in any non-REQ state is ignored.
- Errors:
  - `frame_err` pulses for one cycle.
  - `err_code` updates on the same edge and holds until the next error.
  - Outputs and pending requests are never modified by a rejected frame.

## Timing
- Reset values: every output is 0, the state is IDLE, and the accumulator, payload register and counter are 0.
- Reset asserted mid-frame or mid-request aborts immediately, with no error pulse.
- EOF byte valid in cycle n → on edge n+1:
  - `frame_ok` = 1 for exactly one cycle.
  - `time_2_set`/`date_2_set` are updated.
  - `set_time` (CMD 01/03) or `set_date` (CMD 02) rises.
- `set_done` high in cycle m while in REQ_TIME → on edge m+1, `set_time` = 0.
  - For CMD 03, `set_date` = 1 on the same edge m+1, so there is no gap and no overlap.
- `set_done` held high for several cycles acknowledges only the current request. A set_done still high in the first cycle of REQ_DATE also acknowledges REQ_DATE. The controller must therefore pulse `set_done`.
- Error pulse occurs on the edge after the offending byte. For a timeout, it occurs on the edge after the terminal count.
- Back-to-back valid bytes on consecutive cycles must be accepted.

## Test plan
- Full frame F0 F1 03 24 06 15 06 12 34 56 42 F2, then `set_done` pulsed twice:
  - `frame_ok` pulse, `time_2_set`=24'h123456, `date_2_set`=32'h24061506.
  - `set_time` rises and falls after the first pulse; `set_date` rises on the same edge and falls after the second; then IDLE.
- Frame F0 F1 01 00 00 00 00 12 34 56 71 F2 after the previous test:
  - `time_2_set`=24'h123456, `date_2_set` unchanged, only `set_time` asserted.
- Same CMD 01 frame with CHK=0x70:
  - `frame_err` pulse with `err_code`=2; no request; outputs unchanged.
- F0 F1 07 … → `err_code`=1. A valid frame with last byte 0xF3 → `err_code`=3.
- TIMEOUT_CYC=16; send F0 F1 03 and then stop:
  - `frame_err` with `err_code`=0, 16 cycles after the last byte.
  - A following valid frame is accepted.
- Noise then a split header:
  - Bytes AA F0 F0 F1 followed by a valid CMD 02 frame body → accepted.
  - A second frame sent while `busy` is high is ignored.
  - Assert `rst` mid-request → all outputs 0 immediately.
